// File: rtl/u_rec_fifo.sv
// u_rec_fifo: receive-side byte buffer downstream of the UART receiver.
// Captures each completed byte on the rising edge of the receiver's ready
// level and queues it in a first-word-fall-through FIFO for the host side.
//
// Build option: RXFIFO_OVERWRITE_EN
//   defined   - on overflow the oldest entry is discarded to make room.
//   undefined - on overflow the incoming byte is dropped (default).
//   overflowH is set in both cases.
//
// Ports:
//   sys_clk      system clock (shared with the receiver)
//   sys_rst_l    synchronous active-low reset
//   rec_dataH    received byte, stable while rec_readyH is high
//   rec_readyH   receiver ready level
//   rd_reqH      pop the head entry
//   ovf_clrH     clear the sticky overflow flag
//   fifo_dataH   head entry (don't-care while empty)
//   fifo_emptyH  no entries held
//   fifo_fullH   2^DEPTH_LOG2 entries held
//   fifo_countH  current entry count
//   overflowH    sticky: a byte arrived while full
module u_rec_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_l,
  input  logic [7:0]            rec_dataH,
  input  logic                  rec_readyH,
  input  logic                  rd_reqH,
  input  logic                  ovf_clrH,
  output logic [7:0]            fifo_dataH,
  output logic                  fifo_emptyH,
  output logic                  fifo_fullH,
  output logic [DEPTH_LOG2:0]   fifo_countH,
  output logic                  overflowH
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);
  localparam logic [CntW-1:0]       CntOne   = CntW'(1);
  localparam logic [CntW-1:0]       DepthCnt = CntW'(Depth);

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ready_q;
  logic                  armed_q, armed_d;
  logic                  ovf_q, ovf_d;

  logic empty, full;
  logic wr_evt, ovf_evt;
  logic do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // The receiver raises ready straight out of its own reset; arming only after
  // ready has been seen high keeps that first edge from being captured.
  assign wr_evt  = rec_readyH & ~ready_q & armed_q;
  assign ovf_evt = wr_evt & full & ~rd_reqH;
  assign armed_d = armed_q | rec_readyH;

`ifdef RXFIFO_OVERWRITE_EN
  // Overflow acts as a forced pop plus a write: count stays at depth.
  assign do_rd = (rd_reqH & ~empty) | ovf_evt;
  assign do_wr = wr_evt;
`else
  // A same-cycle pop frees the slot a full FIFO needs.
  assign do_rd = rd_reqH & ~empty;
  assign do_wr = wr_evt & (~full | rd_reqH);
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;

    if (do_wr && !do_rd) begin
      count_d = count_q + CntOne;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CntOne;
    end

    // Set wins over a coincident clear.
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (ovf_clrH) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      armed_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= rec_readyH;
      armed_q  <= armed_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; reset discards contents by clearing the pointers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_l && do_wr) begin
      mem_q[wr_ptr_q] <= rec_dataH;
    end
  end

  assign fifo_dataH  = mem_q[rd_ptr_q];
  assign fifo_emptyH = empty;
  assign fifo_fullH  = full;
  assign fifo_countH = count_q;
  assign overflowH   = ovf_q;

endmodule

// File: tb/tb_u_rec_fifo.sv
// Bench for u_rec_fifo: a table of per-cycle stimulus with expected count and
// overflow, a queue scoreboard for data order, and hand-written reset cases.
module tb_u_rec_fifo;

  localparam int unsigned DL    = 3;
  localparam int          Depth = 1 << DL;

  logic          sys_clk = 1'b0;
  logic          sys_rst_l;
  logic [7:0]    rec_dataH;
  logic          rec_readyH;
  logic          rd_reqH;
  logic          ovf_clrH;
  logic [7:0]    fifo_dataH;
  logic          fifo_emptyH;
  logic          fifo_fullH;
  logic [DL:0]   fifo_countH;
  logic          overflowH;

  u_rec_fifo #(.DEPTH_LOG2(DL)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_l   (sys_rst_l),
    .rec_dataH   (rec_dataH),
    .rec_readyH  (rec_readyH),
    .rd_reqH     (rd_reqH),
    .ovf_clrH    (ovf_clrH),
    .fifo_dataH  (fifo_dataH),
    .fifo_emptyH (fifo_emptyH),
    .fifo_fullH  (fifo_fullH),
    .fifo_countH (fifo_countH),
    .overflowH   (overflowH)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    int         exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // Reference state: the queue holds expected bytes, oldest first.
  logic [7:0] sb[$];
  logic       m_rdy, m_armed, m_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void add(input logic rdy, input logic [7:0] data, input logic rd,
                              input logic clr, input int exp_cnt, input logic exp_ovf);
    vec_t v;
    v.rdy = rdy; v.data = data; v.rd = rd; v.clr = clr;
    v.exp_cnt = exp_cnt; v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", int'(fifo_countH), sb.size());
    chk("empty", int'(fifo_emptyH), int'(sb.size() == 0));
    chk("full", int'(fifo_fullH), int'(sb.size() == Depth));
    chk("overflow", int'(overflowH), int'(m_ovf));
    if (sb.size() > 0) chk("head", int'(fifo_dataH), int'(sb[0]));
  endtask

  // Drive one cycle of inputs, update the reference, sample #1 after the edge.
  task automatic cyc(input logic rdy, input logic [7:0] d, input logic rd, input logic clr);
    logic wr, was_empty, ovf_now;
    rec_readyH = rdy; rec_dataH = d; rd_reqH = rd; ovf_clrH = clr;
    wr        = rdy & ~m_rdy & m_armed;
    was_empty = (sb.size() == 0);
    ovf_now   = 1'b0;
    if (rd && !was_empty) void'(sb.pop_front());
    if (wr) begin
      if (sb.size() < Depth) begin
        sb.push_back(d);
      end else begin
        ovf_now = 1'b1;
`ifdef RXFIFO_OVERWRITE_EN
        void'(sb.pop_front());
        sb.push_back(d);
`endif
      end
    end
    if (ovf_now) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_armed = m_armed | rdy;
    m_rdy   = rdy;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    sys_rst_l = 1'b0;
    rec_readyH = rdy; rec_dataH = 8'h00; rd_reqH = 1'b0; ovf_clrH = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst_l = 1'b1;
    sb.delete();
    m_rdy = 1'b0; m_armed = 1'b0; m_ovf = 1'b0;
  endtask

  initial begin
    // Spurious post-reset edge, then a single byte and its pop.
    add(1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0);
    add(1'b1, 8'hA5, 1'b1, 1'b0, 0, 1'b0);
    // Pop while empty is ignored.
    add(1'b1, 8'hA5, 1'b1, 1'b0, 0, 1'b0);
    // Fill 01..08.
    for (int k = 1; k <= 8; k++) begin
      add(1'b0, 8'h00, 1'b0, 1'b0, k - 1, 1'b0);
      add(1'b1, 8'(k), 1'b0, 1'b0, k, 1'b0);
    end
    // Pop 3, write 09..0B, drain: order 04..0B.
    for (int i = 0; i < 3; i++) add(1'b1, 8'h00, 1'b1, 1'b0, 7 - i, 1'b0);
    for (int i = 0; i < 3; i++) begin
      add(1'b0, 8'h00, 1'b0, 1'b0, 5 + i, 1'b0);
      add(1'b1, 8'(9 + i), 1'b0, 1'b0, 6 + i, 1'b0);
    end
    for (int i = 0; i < 8; i++) add(1'b1, 8'h00, 1'b1, 1'b0, 7 - i, 1'b0);
    // Refill, then overflow with FF, then clear.
    for (int k = 1; k <= 8; k++) begin
      add(1'b0, 8'h00, 1'b0, 1'b0, k - 1, 1'b0);
      add(1'b1, 8'(k), 1'b0, 1'b0, k, 1'b0);
    end
    add(1'b0, 8'h00, 1'b0, 1'b0, 8, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 1'b0, 8, 1'b1);
    add(1'b1, 8'hFF, 1'b0, 1'b1, 8, 1'b0);
    // Full with write and pop in the same cycle: no overflow.
    add(1'b0, 8'h00, 1'b0, 1'b0, 8, 1'b0);
    add(1'b1, 8'h55, 1'b1, 1'b0, 8, 1'b0);
    // Clear coincident with a new overflow: set wins.
    add(1'b0, 8'h00, 1'b0, 1'b0, 8, 1'b0);
    add(1'b1, 8'h66, 1'b0, 1'b1, 8, 1'b1);
    for (int i = 0; i < 8; i++) add(1'b1, 8'h00, 1'b1, 1'b0, 7 - i, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b0);

    sys_rst_l = 1'b0;
    rec_readyH = 1'b0; rec_dataH = 8'h00; rd_reqH = 1'b0; ovf_clrH = 1'b0;
    m_rdy = 1'b0; m_armed = 1'b0; m_ovf = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    do_reset(1'b0);
    chk("rst_count", int'(fifo_countH), 0);
    chk("rst_empty", int'(fifo_emptyH), 1);
    chk("rst_full", int'(fifo_fullH), 0);
    chk("rst_ovf", int'(overflowH), 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rdy, vecs[i].data, vecs[i].rd, vecs[i].clr);
      chk($sformatf("tbl_count[%0d]", i), int'(fifo_countH), vecs[i].exp_cnt);
      chk($sformatf("tbl_ovf[%0d]", i), int'(overflowH), int'(vecs[i].exp_ovf));
      check_state();
    end

    // Reset pulse with 5 entries held, ready kept high through and after it.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
    end
    chk("pre_rst_count", int'(fifo_countH), 5);
    chk("pre_rst_head", int'(fifo_dataH), 8'h20);
    do_reset(1'b1);
    chk("mid_rst_count", int'(fifo_countH), 0);
    chk("mid_rst_empty", int'(fifo_emptyH), 1);
    // Ready high right after reset is the arming cycle, not a capture.
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("disarmed_count", int'(fifo_countH), 0);
    check_state();
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("held_ready_count", int'(fifo_countH), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h88, 1'b0, 1'b0);
    chk("rearm_count", int'(fifo_countH), 1);
    chk("rearm_head", int'(fifo_dataH), 8'h88);
    check_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/u_rec_fifo.md
# u_rec_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It watches the receiver's ready level, captures each newly completed byte on the ready rising edge, and queues it in a first-word-fall-through FIFO for the host-side consumer. It flags overflow when bytes arrive faster than the consumer drains them.

## Interface
- DEPTH_LOG2, 3: log2 of FIFO depth (depth = 8 by default); legal range 1..6.
- sys_clk  input  1  system clock; same clock as the receiver.
- sys_rst_l  input  1  reset. Synchronous, active-low.
- rec_dataH  input  8  received byte from the receiver; stable while rec_readyH is high.
- rec_readyH  input  1  receiver ready level; low during reception, high when idle or a byte is complete.
- rd_reqH  input  1  consumer pops the head entry this cycle.
- ovf_clrH  input  1  clears the sticky overflow flag.
- fifo_dataH  output  8  head (oldest) entry; valid while fifo_emptyH is low.
- fifo_emptyH  output  1  FIFO holds no entries.
- fifo_fullH  output  1  FIFO holds 2^DEPTH_LOG2 entries.
- fifo_countH  output  DEPTH_LOG2+1  current entry count.
- overflowH  output  1  sticky: a byte arrived while the FIFO was full.

## Operation
- Edge detect:
  - Register rec_readyH into ready_d.
  - wr_evt = rec_readyH & ~ready_d & armed.
- Arming:
  - armed clears on reset.
  - armed sets on the first cycle rec_readyH is sampled high.
  - Purpose: the receiver raises ready right after its own reset with data 8'h00, and that first rising edge must not be captured.
- Storage:
  - Register array of 2^DEPTH_LOG2 x 8.
  - Write pointer, read pointer and count.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Write: on wr_evt while not full, store rec_dataH at the write pointer, advance the write pointer, and increment the count.
- Read:
  - On rd_reqH while not empty, advance the read pointer and decrement the count.
  - rd_reqH while empty is ignored; no state change.
- FWFT: fifo_dataH = mem[rd_ptr] combinationally. Its value while empty is don't-care.
- Simultaneous write and read:
  - Not empty: both are performed; count unchanged.
  - Empty: the write is performed and the read is ignored; there is no bypass.
  - Full: the read frees a slot and the write is accepted; count unchanged; no overflow.
- Overflow (wr_evt while full and no rd_reqH):
  - Handled per the Configuration section.
  - overflowH sets in both configurations.
- overflowH clears on ovf_clrH. If a set and a clear occur in the same cycle, the set wins.
- fifo_emptyH = (count == 0). fifo_fullH = (count == depth). Both are decoded from the registered count.

## Timing
- Reset values:
  - fifo_emptyH = 1, fifo_fullH = 0, fifo_countH = 0, overflowH = 0.
  - Pointers = 0, ready_d = 0, armed = 0.
  - Memory contents are not reset.
- Capture latency: rec_readyH rises in cycle N; the write happens on the clock edge ending cycle N. From cycle N+1, fifo_emptyH = 0, fifo_countH is incremented, and fifo_dataH shows the byte if it is the head.
- Pop latency: rd_reqH high in cycle N; fifo_dataH presents the next entry and the count is decremented from cycle N+1.
- The minimum spacing between receiver bytes is more than 100 cycles, so at most one wr_evt occurs per byte.
- Reset asserted mid-operation: all contents are discarded at the next clock edge. The block re-arms only after rec_readyH is sampled high again.
- rec_readyH held high for many cycles produces exactly one write per rising edge.

## Configuration
- RXFIFO_OVERWRITE_EN:
  - Defined: on overflow the oldest entry is discarded. The read pointer advances, the new byte is written, count stays at depth, and overflowH sets. The FIFO always holds the most recent bytes.
  - Undefined (default): on overflow the incoming byte is dropped, with pointers and count unchanged. overflowH sets. The FIFO holds the oldest bytes.

## Test plan
- Post-reset spurious edge: release reset; rec_readyH goes 0→1 with rec_dataH = 8'h00 -> fifo_emptyH stays 1 and fifo_countH = 0.
- Single byte: after arming, rec_readyH 1→0→1 with rec_dataH = 8'hA5 -> next cycle fifo_emptyH = 0, fifo_dataH = 8'hA5, fifo_countH = 1. Then rd_reqH for one cycle -> fifo_emptyH = 1.
- Fill and wrap (DEPTH_LOG2 = 3): write 8'h01..8'h08 -> fifo_fullH = 1, count = 8. Pop 3 and write 8'h09..8'h0B -> pop order is 04..0B.
- Overflow drop (macro off): full with 01..08, then write 8'hFF -> overflowH = 1, head still 8'h01, count = 8. ovf_clrH -> overflowH = 0.
- Overflow overwrite (macro on): same stimulus -> overflowH = 1, pop order 02..08, FF.
- Corner cases:
  - Full, with wr_evt and rd_reqH in the same cycle -> count stays 8 and overflowH stays 0.
  - Empty, with rd_reqH only -> count stays 0.
  - ovf_clrH coincident with a new overflow -> overflowH = 1.
  - Reset pulse while count = 5 -> count = 0 and the block is disarmed.
